// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-access encodings and uncached FSM state type
package mem_pkg;

   // Final memory access types produced by address translation
   typedef enum logic [1:0] {
      MAT_SUC = 2'b00,
      MAT_CC  = 2'b01,
      MAT_WUC = 2'b10
   } mat_e;

   // Access size codes as carried on req_size
   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   typedef enum logic [2:0] {
      UC_IDLE,
      UC_DRAIN,
      UC_RD_ADDR,
      UC_RD_DATA,
      UC_WR_REQ,
      UC_WR_RESP,
      UC_RESP
   } uc_state_e;

   // Ordering gate: posted (WUC) stores only need a free slot, everything
   // else must wait until every posted write has been acknowledged.
   function automatic logic drain_ok(input logic we, input logic wuc,
                                     input logic empty, input logic full);
      return (we && wuc) ? !full : empty;
   endfunction

endpackage

// File: rtl/posted_wr_cnt.sv
// rtl/posted_wr_cnt.sv - saturating count of posted writes awaiting a B response
module posted_wr_cnt #(
   parameter int MAX_POSTED = 4
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full,
   output logic o_empty
);

   localparam int CW = $clog2(MAX_POSTED + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_POSTED);

   logic [CW-1:0] r_count;

   // Up/down count; a simultaneous inc and dec cancel out
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && !i_dec && r_count != MAX_CNT) begin
         r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc && r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_full  = (r_count == MAX_CNT);
   assign o_empty = (r_count == '0);

   // Overflow/underflow would mean a lost or spurious B response
   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         assert (!(i_inc && !i_dec && o_full));
         assert (!(i_dec && !i_inc && o_empty));
      end
   end

endmodule

// File: rtl/uncached_access_unit.sv
// rtl/uncached_access_unit.sv - single-beat SUC/WUC bus access engine for the memory pipeline
module uncached_access_unit
   import mem_pkg::*;
#(
   parameter int MAX_POSTED = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_mat,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [3:0]        req_wstrb,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              ar_valid,
   input  logic              ar_ready,
   output logic [ADDR_W-1:0] ar_addr,
   output logic [2:0]        ar_size,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [31:0]       r_data,
   output logic              aw_valid,
   input  logic              aw_ready,
   output logic [ADDR_W-1:0] aw_addr,
   output logic [2:0]        aw_size,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [31:0]       w_data,
   output logic [3:0]        w_strb,
   input  logic              b_valid,
   output logic              b_ready,
   output logic              posted_empty
);

   uc_state_e         r_state;
   uc_state_e         w_state_nxt;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_req_we;
   logic              r_req_wuc;
   logic [1:0]        r_req_size;
   logic [3:0]        r_req_wstrb;
   logic [31:0]       r_req_wdata;
   logic [31:0]       r_rdata;
   logic              r_aw_done;
   logic              r_w_done;

   logic w_accept;
   logic w_req_wuc;
   logic w_accept_go;
   logic w_drain_go;
   logic w_aw_hs;
   logic w_w_hs;
   logic w_wr_done;
   logic w_inc;
   logic w_dec;
   logic w_full;
   logic w_empty;

   assign w_accept    = req_valid && req_ready;
   assign w_req_wuc   = (req_mat == MAT_WUC);
   assign w_accept_go = drain_ok(req_we, w_req_wuc, w_empty, w_full);
   assign w_drain_go  = drain_ok(r_req_we, r_req_wuc, w_empty, w_full);
   assign w_aw_hs     = aw_valid && aw_ready;
   assign w_w_hs      = w_valid && w_ready;
   assign w_wr_done   = (r_state == UC_WR_REQ) && (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);
   assign w_inc       = w_wr_done && r_req_wuc;
   // A B seen while waiting on a SUC store belongs to that store, not a posted one
   assign w_dec       = b_valid && (r_state != UC_WR_RESP);

   posted_wr_cnt #(.MAX_POSTED(MAX_POSTED)) u_posted_cnt (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_inc   (w_inc),
      .i_dec   (w_dec),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Next-state selection; DRAIN is skipped when the ordering gate is already open
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         UC_IDLE: begin
            if (w_accept) begin
               if (w_accept_go) w_state_nxt = req_we ? UC_WR_REQ : UC_RD_ADDR;
               else             w_state_nxt = UC_DRAIN;
            end
         end
         UC_DRAIN:   if (w_drain_go) w_state_nxt = r_req_we ? UC_WR_REQ : UC_RD_ADDR;
         UC_RD_ADDR: if (ar_ready)   w_state_nxt = UC_RD_DATA;
         UC_RD_DATA: if (r_valid)    w_state_nxt = UC_RESP;
         UC_WR_REQ:  if (w_wr_done)  w_state_nxt = r_req_wuc ? UC_RESP : UC_WR_RESP;
         UC_WR_RESP: if (b_valid)    w_state_nxt = UC_RESP;
         UC_RESP:    if (resp_ready) w_state_nxt = UC_IDLE;
         default:                    w_state_nxt = UC_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= UC_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Request latch, read-data capture and per-channel write handshake tracking
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_req_addr  <= '0;
         r_req_we    <= 1'b0;
         r_req_wuc   <= 1'b0;
         r_req_size  <= 2'd0;
         r_req_wstrb <= 4'd0;
         r_req_wdata <= 32'd0;
         r_rdata     <= 32'd0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_req_addr  <= req_addr;
            r_req_we    <= req_we;
            r_req_wuc   <= w_req_wuc;
            r_req_size  <= req_size;
            r_req_wstrb <= req_wstrb;
            r_req_wdata <= req_wdata;
            r_rdata     <= 32'd0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
         end
         if (r_state == UC_RD_DATA && r_valid) r_rdata <= r_data;
         if (w_aw_hs) r_aw_done <= 1'b1;
         if (w_w_hs)  r_w_done  <= 1'b1;
      end
   end

   // Only SUC and WUC may reach this unit; anything else is handled as SUC
   always_ff @(posedge aclk) begin
      if (aresetn && w_accept) assert (req_mat == MAT_SUC || req_mat == MAT_WUC);
   end

   assign req_ready    = (r_state == UC_IDLE);
   assign ar_valid     = (r_state == UC_RD_ADDR);
   assign ar_addr      = r_req_addr;
   assign ar_size      = {1'b0, r_req_size};
   assign r_ready      = (r_state == UC_RD_DATA);
   assign aw_valid     = (r_state == UC_WR_REQ) && !r_aw_done;
   assign aw_addr      = r_req_addr;
   assign aw_size      = {1'b0, r_req_size};
   assign w_valid      = (r_state == UC_WR_REQ) && !r_w_done;
   assign w_data       = r_req_wdata;
   assign w_strb       = r_req_wstrb;
   assign b_ready      = 1'b1;
   assign resp_valid   = (r_state == UC_RESP);
   assign resp_rdata   = r_rdata;
   assign posted_empty = w_empty;

endmodule

// File: tb/tb_uncached_access_unit.sv
// tb/tb_uncached_access_unit.sv - directed scoreboard bench for uncached_access_unit
module tb_uncached_access_unit;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic [1:0]  req_mat = 2'b00;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [3:0]  req_wstrb = 4'd0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic [2:0]  ar_size;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic        aw_valid;
   logic        aw_ready;
   logic [31:0] aw_addr;
   logic [2:0]  aw_size;
   logic        w_valid;
   logic        w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_valid = 1'b0;
   logic        b_ready;
   logic        posted_empty;

   int          nvec = 0;
   int          nerr = 0;
   logic [31:0] sb[$];
   int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0;
   logic [31:0] rd_word = '0;

   always #5 aclk = ~aclk;

   uncached_access_unit #(.MAX_POSTED(4), .ADDR_W(32)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_mat(req_mat), .req_we(req_we), .req_size(req_size),
      .req_wstrb(req_wstrb), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_size(aw_size),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
      .b_valid(b_valid), .b_ready(b_ready),
      .posted_empty(posted_empty)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   // Slave model: each ready/valid answer comes <lat> cycles after the DUT asks
   task automatic bus_model();
      int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0;
      ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; aw_ready = 1'b0; w_ready = 1'b0;
      forever begin
         @(negedge aclk);
         if (ar_valid && !ar_ready) begin
            if (ar_c >= ar_lat) ar_ready = 1'b1; else ar_c++;
         end else begin
            ar_ready = 1'b0; ar_c = 0;
         end
         if (r_ready && !r_valid) begin
            if (r_c >= r_lat) begin r_valid = 1'b1; r_data = rd_word; end else r_c++;
         end else begin
            r_valid = 1'b0; r_c = 0;
         end
         if (aw_valid && !aw_ready) begin
            if (aw_c >= aw_lat) aw_ready = 1'b1; else aw_c++;
         end else begin
            aw_ready = 1'b0; aw_c = 0;
         end
         if (w_valid && !w_ready) begin
            if (w_c >= w_lat) w_ready = 1'b1; else w_c++;
         end else begin
            w_ready = 1'b0; w_c = 0;
         end
      end
   endtask

   // Present one request and return in the first cycle after it is accepted
   task automatic issue(input logic we, input logic [1:0] mat, input logic [31:0] addr,
                        input logic [1:0] size, input logic [3:0] strb, input logic [31:0] data);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_mat = mat; req_addr = addr;
      req_size = size; req_wstrb = strb; req_wdata = data;
      while (!req_ready && n < 50) begin cyc(); n++; end
      check("req_ready", req_ready, 1);
      cyc();
      req_valid = 1'b0;
   endtask

   // Wait for a completion, compare against the scoreboard, optionally stall it
   task automatic get_resp(input string tag, input int hold, output int lat);
      int n = 0;
      logic [31:0] expd;
      while (!resp_valid && n < 200) begin cyc(); n++; end
      lat = n + 1;
      check({tag, "_resp_valid"}, resp_valid, 1);
      expd = 32'hxxxxxxxx;
      if (sb.size() != 0) expd = sb.pop_front();
      check({tag, "_rdata"}, resp_rdata, expd);
      for (int i = 0; i < hold; i++) begin
         cyc();
         check({tag, "_hold_valid"}, resp_valid, 1);
         check({tag, "_hold_rdata"}, resp_rdata, expd);
      end
      resp_ready = 1'b1;
      cyc();
      resp_ready = 1'b0;
      check({tag, "_resp_drop"}, resp_valid, 0);
   endtask

   task automatic b_pulse();
      b_valid = 1'b1;
      cyc();
      b_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ar_valid"}, ar_valid, 0);
      check({tag, "_aw_valid"}, aw_valid, 0);
      check({tag, "_w_valid"}, w_valid, 0);
      check({tag, "_r_ready"}, r_ready, 0);
      check({tag, "_resp_valid"}, resp_valid, 0);
      check({tag, "_req_ready"}, req_ready, 1);
   endtask

   initial begin
      int lat;
      int n;
      fork bus_model(); join_none

      // Reset values
      repeat (2) cyc();
      check_idle_outputs("rst");
      check("rst_b_ready", b_ready, 1);
      check("rst_posted_empty", posted_empty, 1);
      check("rst_resp_rdata", resp_rdata, 0);
      aresetn = 1'b1;
      cyc();

      // SUC load, single-cycle slave delays
      rd_word = 32'hDEADBEEF; ar_lat = 1; r_lat = 1;
      sb.push_back(32'hDEADBEEF);
      issue(1'b0, 2'b00, 32'h1FE001E0, 2'd2, 4'h0, 32'h0);
      check("ld_ar_valid", ar_valid, 1);
      check("ld_ar_addr", ar_addr, 32'h1FE001E0);
      check("ld_ar_size", ar_size, 3'd2);
      get_resp("suc_ld", 0, lat);
      check("suc_ld_latency", lat, 5);
      ar_lat = 0; r_lat = 0;

      // WUC byte store, AW accepted 3 cycles before W, B withheld
      aw_lat = 0; w_lat = 3;
      sb.push_back(32'h0);
      issue(1'b1, 2'b10, 32'h1FE00101, 2'd0, 4'b0010, 32'h0000AB00);
      check("wuc_aw_valid", aw_valid, 1);
      check("wuc_w_valid", w_valid, 1);
      check("wuc_aw_addr", aw_addr, 32'h1FE00101);
      check("wuc_aw_size", aw_size, 3'd0);
      check("wuc_w_strb", w_strb, 4'b0010);
      check("wuc_w_data", w_data, 32'h0000AB00);
      cyc();
      check("wuc_aw_dropped", aw_valid, 0);
      check("wuc_w_held", w_valid, 1);
      get_resp("wuc_st", 0, lat);
      check("wuc_posted_pending", posted_empty, 0);
      b_pulse();
      check("wuc_posted_cleared", posted_empty, 1);
      w_lat = 0;

      // Fill all posted slots, fifth store must wait in DRAIN
      for (int i = 0; i < 4; i++) begin
         sb.push_back(32'h0);
         issue(1'b1, 2'b10, 32'h00001000 + 32'(i * 4), 2'd2, 4'hF, 32'hA0 + 32'(i));
         get_resp("fill", 0, lat);
      end
      sb.push_back(32'h0);
      issue(1'b1, 2'b10, 32'h00001010, 2'd2, 4'hF, 32'hA4);
      for (int i = 0; i < 3; i++) begin
         check("fifth_aw_blocked", aw_valid, 0);
         check("fifth_busy", req_ready, 0);
         cyc();
      end
      b_pulse();
      get_resp("fifth", 0, lat);
      for (int i = 0; i < 3; i++) begin
         b_pulse();
         check("fifth_count_4", posted_empty, 0);
      end
      b_pulse();
      check("fifth_drained", posted_empty, 1);

      // SUC load behind two posted stores
      for (int i = 0; i < 2; i++) begin
         sb.push_back(32'h0);
         issue(1'b1, 2'b10, 32'h00002000 + 32'(i * 4), 2'd2, 4'hF, 32'hB0);
         get_resp("pre_ld", 0, lat);
      end
      rd_word = 32'h12345678;
      sb.push_back(32'h12345678);
      issue(1'b0, 2'b00, 32'h00003000, 2'd1, 4'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin check("ord_ar_wait2", ar_valid, 0); cyc(); end
      b_pulse();
      for (int i = 0; i < 2; i++) begin check("ord_ar_wait1", ar_valid, 0); cyc(); end
      b_pulse();
      n = 0;
      while (!ar_valid && n < 10) begin cyc(); n++; end
      check("ord_ar_raised", ar_valid, 1);
      check("ord_ar_size", ar_size, 3'd1);
      get_resp("ord_ld", 0, lat);

      // B arriving in the same cycle as a WUC increment
      sb.push_back(32'h0);
      issue(1'b1, 2'b10, 32'h00004000, 2'd2, 4'hF, 32'hC0);
      get_resp("sim_a", 0, lat);
      sb.push_back(32'h0);
      issue(1'b1, 2'b10, 32'h00004004, 2'd2, 4'hF, 32'hC1);
      b_pulse();
      get_resp("sim_b", 0, lat);
      check("sim_count_1", posted_empty, 0);
      b_pulse();
      check("sim_drained", posted_empty, 1);

      // SUC store waits for B; response stalled 3 cycles
      sb.push_back(32'h0);
      issue(1'b1, 2'b00, 32'h00005000, 2'd2, 4'hF, 32'h55AA55AA);
      for (int i = 0; i < 3; i++) begin check("suc_st_no_early_resp", resp_valid, 0); cyc(); end
      check("suc_st_no_early_resp", resp_valid, 0);
      b_pulse();
      get_resp("suc_st", 3, lat);
      check("suc_st_posted_empty", posted_empty, 1);

      // Reset during RD_DATA
      r_lat = 20; rd_word = 32'hCAFEF00D;
      issue(1'b0, 2'b00, 32'h00006000, 2'd2, 4'h0, 32'h0);
      n = 0;
      while (!r_ready && n < 10) begin cyc(); n++; end
      check("rst_rd_in_rd_data", r_ready, 1);
      aresetn = 1'b0;
      #1;
      check_idle_outputs("rst_rd");
      cyc();
      aresetn = 1'b1;
      r_lat = 0;
      cyc();

      // Reset during WR_REQ with a posted write outstanding
      sb.push_back(32'h0);
      issue(1'b1, 2'b10, 32'h00007000, 2'd2, 4'hF, 32'hD0);
      get_resp("pre_rst", 0, lat);
      check("pre_rst_posted", posted_empty, 0);
      aw_lat = 20; w_lat = 20;
      issue(1'b1, 2'b10, 32'h00007004, 2'd2, 4'hF, 32'hD1);
      check("rst_wr_in_wr_req", aw_valid, 1);
      aresetn = 1'b0;
      #1;
      check_idle_outputs("rst_wr");
      check("rst_wr_posted_empty", posted_empty, 1);
      cyc();
      aresetn = 1'b1;
      aw_lat = 0; w_lat = 0;
      cyc();
      check("post_rst_posted_empty", posted_empty, 1);

      // Normal operation after reset
      rd_word = 32'h0BADF00D;
      sb.push_back(32'h0BADF00D);
      issue(1'b0, 2'b10, 32'h00008000, 2'd2, 4'h0, 32'h0);
      get_resp("post_rst_ld", 0, lat);
      check("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
